// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and the breadboard/monitor side.
// The master modport is the sweeper end; the slave modport is the function block and log consumer.
interface truth_table_sweeper_if;
    logic       start;
    logic [3:0] vec_out;
    logic [2:0] resp_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_idx;
    logic       first_err_vld;
    logic       log_valid;
    logic [3:0] log_idx;
    logic [2:0] log_resp;
    logic [2:0] log_exp;
    logic       log_mismatch;

    modport master (
        input  start, resp_in,
        output vec_out, busy, done, pass, err_count, first_err_idx, first_err_vld,
               log_valid, log_idx, log_resp, log_exp, log_mismatch
    );

    modport slave (
        output start, resp_in,
        input  vec_out, busy, done, pass, err_count, first_err_idx, first_err_vld,
               log_valid, log_idx, log_resp, log_exp, log_mismatch
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps {w,x,y,z} through 0..15, samples {f4,f5,f6} after a settle window and
// checks each sample against EXP_TABLE, logging per vector and summarising the sweep.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [47:0] EXP_TABLE  = 48'h80A_803_80A_EDA
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.master bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;
    localparam logic       NO_SETTLE   = (SETTLE_CYC == 0);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_q, err_d;
    logic [3:0] fidx_q, fidx_d;
    logic       fvld_q, fvld_d;
    logic       lvld_q, lvld_d;
    logic [3:0] lidx_q, lidx_d;
    logic [2:0] lresp_q, lresp_d;
    logic [2:0] lexp_q, lexp_d;
    logic       lmis_q, lmis_d;

    logic [5:0] exp_base;
    logic [2:0] exp_w;
    logic       mism_w;

    // Bit offset 3*idx built from shifts to keep the select index narrow.
    assign exp_base = {1'b0, vec_q, 1'b0} + {2'b00, vec_q};
    assign exp_w    = EXP_TABLE[exp_base +: 3];
    assign mism_w   = (bus.resp_in != exp_w);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fvld_d  = fvld_q;
        lvld_d  = 1'b0;
        lidx_d  = lidx_q;
        lresp_d = lresp_q;
        lexp_d  = lexp_q;
        lmis_d  = lmis_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    err_d  = '0;
                    pass_d = 1'b0;
                    fvld_d = 1'b0;
                    fidx_d = '0;
                    busy_d = 1'b1;
                    vec_d  = '0;
                    cnt_d  = SETTLE_LOAD;
                    state_d = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                lvld_d  = 1'b1;
                lidx_d  = vec_q;
                lresp_d = bus.resp_in;
                lexp_d  = exp_w;
                lmis_d  = mism_w;
                if (mism_w) begin
                    err_d = err_q + 5'd1;
                    if (!fvld_q) begin
                        fidx_d = vec_q;
                        fvld_d = 1'b1;
                    end
                end
                if (vec_q == 4'd15) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Uses the updated count so the last vector's mismatch is included.
                    pass_d  = (err_d == 5'd0);
                end else begin
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fvld_q  <= 1'b0;
            lvld_q  <= 1'b0;
            lidx_q  <= '0;
            lresp_q <= '0;
            lexp_q  <= '0;
            lmis_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fvld_q  <= fvld_d;
            lvld_q  <= lvld_d;
            lidx_q  <= lidx_d;
            lresp_q <= lresp_d;
            lexp_q  <= lexp_d;
            lmis_q  <= lmis_d;
        end
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = fidx_q;
    assign bus.first_err_vld = fvld_q;
    assign bus.log_valid     = lvld_q;
    assign bus.log_idx       = lidx_q;
    assign bus.log_resp      = lresp_q;
    assign bus.log_exp       = lexp_q;
    assign bus.log_mismatch  = lmis_q;
endmodule
